// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
//   N      : number of requesters (matches the 8:1 mux width)
//   SEL_W  : width of the encoded mux select
//   arb_state_t : arbiter FSM states
//   req_vec_t   : one bit per requester
package mux8_arb_pkg;
    localparam int unsigned N     = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {IDLE, BUSY} arb_state_t;
    typedef logic [N-1:0] req_vec_t;
endpackage

// File: rtl/rr_pick8.sv
// Circular first-set-bit picker: scans req starting at index start
// (start, start+1, ..., 7, 0, ...) and reports the first set bit.
// Ports:
//   req    in  [7:0]  candidate requests
//   start  in  [2:0]  index where the circular scan begins
//   onehot out [7:0]  one-hot winner, zero when nothing is set
//   idx    out [2:0]  encoded winner, zero when nothing is set
//   any    out        at least one request set
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;
    logic             found;

    // Rotate so that bit 'start' lands at position 0, priority-encode the
    // lowest set bit, then add start back to undo the rotation.
    always_comb begin
        dbl   = {req, req};
        rot   = dbl[{1'b0, start} +: N];
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                off   = SEL_W'(i);
                found = 1'b1;
            end
        end
        any    = found;
        idx    = found ? SEL_W'(start + off) : '0;
        onehot = found ? (req_vec_t'(1) << idx) : '0;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing an 8:1 single-bit mux between eight
// requesters. The owner keeps the grant while its request stays high, but
// after MAX_HOLD consecutive cycles it is rotated out if anyone else waits.
// Ports:
//   clk   in        rising-edge clock
//   rst   in        synchronous active-high reset
//   req   in  [7:0] request vector, bit i = requester i
//   gnt   out [7:0] registered one-hot grant, zero when idle
//   sel   out [2:0] registered mux select (index of the owner)
//   valid out       registered, high while a grant is active
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [3:0]       hold_q, hold_d;
    logic [N-1:0]     gnt_d;
    logic [SEL_W-1:0] sel_d;
    logic             valid_d;

    logic [N-1:0]     pick_onehot;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             own;
    logic             take_new;

    // ptr always equals owner+1 while BUSY, so a single picker scanning
    // req & ~gnt from ptr serves both the idle pick and the next-after-owner
    // pick; masking with ~gnt makes pick_any mean "others pending".
    rr_pick8 u_pick (
        .req    (req & ~gnt),
        .start  (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign own = |(req & gnt);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_d    = gnt;
        sel_d    = sel;
        valid_d  = valid;
        take_new = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) take_new = 1'b1;
            end
            BUSY: begin
                if (!own) begin
                    if (pick_any) begin
                        take_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (hold_q < 4'(MAX_HOLD)) begin
                    hold_d = hold_q + 4'd1;
                end else if (pick_any) begin
                    take_new = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_new) begin
            state_d = BUSY;
            gnt_d   = pick_onehot;
            sel_d   = pick_idx;
            valid_d = 1'b1;
            hold_d  = 4'd1;
            ptr_d   = pick_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt     <= '0;
            sel     <= '0;
            valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt     <= gnt_d;
            sel     <= sel_d;
            valid   <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                       input logic [2:0] s, input logic v);
        vec_t e;
        e.rst = r; e.req = q; e.gnt = g; e.sel = s; e.valid = v;
        vecs.push_back(e);
    endtask

    // Drive inputs, let one rising edge pass, then sample 1 time unit later.
    task automatic step(input logic r, input logic [7:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g,
                              input logic [2:0] s, input logic v);
        chk({tag, ".gnt"},   gnt,   g);
        chk({tag, ".sel"},   sel,   s);
        chk({tag, ".valid"}, valid, v);
    endtask

    int unsigned wait_c [8];
    logic [7:0]  rq;

    initial begin
        rst = 1'b1;
        req = '0;

        // Reset, release, basic grant.
        add(1, 8'hFF, 8'h00, 0, 0);
        add(1, 8'hFF, 8'h00, 0, 0);
        add(0, 8'h01, 8'h01, 0, 1);
        // Re-reset to bring ptr back to 0, then 0 -> 7 handoff and wrap.
        add(1, 8'h00, 8'h00, 0, 0);
        add(0, 8'h81, 8'h01, 0, 1);
        add(0, 8'h80, 8'h80, 7, 1);
        add(0, 8'h00, 8'h00, 7, 0);
        add(0, 8'h81, 8'h01, 0, 1);
        // Hold limit rotation between 0 and 2 (owner 0 already has 1 cycle).
        for (int unsigned i = 0; i < 3; i++) add(0, 8'h05, 8'h01, 0, 1);
        for (int unsigned i = 0; i < 4; i++) add(0, 8'h05, 8'h04, 2, 1);
        for (int unsigned i = 0; i < 4; i++) add(0, 8'h05, 8'h01, 0, 1);
        add(0, 8'h05, 8'h04, 2, 1);
        add(0, 8'h00, 8'h00, 2, 0);

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].req);
            expect_out($sformatf("vec%0d", k), vecs[k].gnt, vecs[k].sel, vecs[k].valid);
        end

        // Lone requester keeps the grant past MAX_HOLD (saturation).
        step(0, 8'h10);
        expect_out("solo_first", 8'h10, 4, 1);
        for (int unsigned i = 0; i < 20; i++) begin
            step(0, 8'h10);
            expect_out($sformatf("solo%0d", i), 8'h10, 4, 1);
        end

        // Reset in the middle of a grant, then ptr must be back at 0.
        step(0, 8'h08);
        expect_out("pre_rst", 8'h08, 3, 1);
        step(1, 8'h08);
        expect_out("mid_rst", 8'h00, 0, 0);
        step(0, 8'h48);
        expect_out("post_rst", 8'h08, 3, 1);

        // Random traffic with invariant and starvation checks.
        step(1, 8'h00);
        foreach (wait_c[i]) wait_c[i] = 0;
        rq = '0;
        for (int unsigned c = 0; c < 10000; c++) begin
            for (int unsigned b = 0; b < 8; b++)
                if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            step(0, rq);
            chk("onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
            chk("valid_or", valid, |gnt);
            if (valid) chk("gnt_sel", gnt, 8'h01 << sel);
            // Mux with A = gnt: Y = A[S] must equal valid.
            chk("mux_y", gnt[sel], valid);
            for (int unsigned b = 0; b < 8; b++) begin
                if (req[b] && !gnt[b]) wait_c[b]++;
                else wait_c[b] = 0;
                if (wait_c[b] > 29) begin
                    chk($sformatf("starve%0d", b), wait_c[b], 29);
                    wait_c[b] = 0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
